// File: rtl/uart_dds_ctrl.sv
// rtl/uart_dds_ctrl.sv - 8N1 UART command receiver issuing DDS register writes
//
// Frames: HEADER, addr, data_hi, data_lo, chk (chk = addr ^ data_hi ^ data_lo).
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   uart_rx    serial input, idle high, asynchronous to clk
//   wr         one-cycle write strobe per accepted frame
//   waddr      {8'h00, addr}; valid with wr, held afterwards
//   wdata      {data_hi, data_lo}; valid with wr, held afterwards
//   frame_ok   one-cycle pulse coincident with wr
//   frame_err  one-cycle pulse on checksum, framing or timeout error
//   err_count  saturating error counter
//   rx_busy    high while the bit receiver is inside a character
module uart_dds_ctrl #(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          BAUD        = 115200,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          TIMEOUT_CYC = 43400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        wr,
    output logic [15:0] waddr,
    output logic [15:0] wdata,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        rx_busy
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_ADDR, P_DHI, P_DLO, P_CHK} p_state_t;

    // Bit receiver
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            stop_done_q, stop_done_d;
    logic            stop_bit_q, stop_bit_d;
    logic            byte_valid_q, frm_err_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q + CW'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_done_d = 1'b0;
        stop_bit_d  = stop_bit_q;
        case (rx_state_q)
            R_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = R_START;
            end
            R_START: begin
                // Mid-start-bit check rejects short glitches without an error.
                if (cnt_q == CW'(DIV / 2 - 1)) begin
                    cnt_d      = '0;
                    bit_d      = 3'd0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d       = '0;
                    stop_done_d = 1'b1;
                    stop_bit_d  = rx_sync_q;
                    rx_state_d  = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= R_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            stop_done_q  <= 1'b0;
            stop_bit_q   <= 1'b1;
            byte_valid_q <= 1'b0;
            frm_err_q    <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            stop_done_q  <= stop_done_d;
            stop_bit_q   <= stop_bit_d;
            // shift_q stays stable until the next character's data phase.
            byte_valid_q <= stop_done_q & stop_bit_q;
            frm_err_q    <= stop_done_q & ~stop_bit_q;
        end
    end

    // Frame parser
    p_state_t        p_q, p_d;
    logic [7:0]      addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            wr_q, wr_d, frame_err_q, frame_err_d;
    logic [15:0]     waddr_q, waddr_d, wdata_q, wdata_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            timeout_hit, chk_ok, err_evt;

    // to_cnt_q holds cycles elapsed since the last byte_valid.
    assign timeout_hit = (p_q != P_HDR) && !byte_valid_q &&
                         (to_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign chk_ok      = (shift_q == (addr_q ^ dhi_q ^ dlo_q));

    always_comb begin
        p_d      = p_q;
        addr_d   = addr_q;
        dhi_d    = dhi_q;
        dlo_d    = dlo_q;
        wr_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_evt  = 1'b0;
        if (byte_valid_q)      to_cnt_d = TW'(1);
        else if (p_q == P_HDR) to_cnt_d = '0;
        else                   to_cnt_d = to_cnt_q + TW'(1);

        // Framing error and timeout in the same cycle collapse to one event.
        if (frm_err_q || timeout_hit) begin
            err_evt = 1'b1;
            p_d     = P_HDR;
        end else if (byte_valid_q) begin
            case (p_q)
                P_HDR:  if (shift_q == HEADER) p_d = P_ADDR;
                P_ADDR: begin addr_d = shift_q; p_d = P_DHI; end
                P_DHI:  begin dhi_d  = shift_q; p_d = P_DLO; end
                P_DLO:  begin dlo_d  = shift_q; p_d = P_CHK; end
                P_CHK: begin
                    p_d = P_HDR;
                    if (chk_ok) begin
                        wr_d    = 1'b1;
                        waddr_d = {8'h00, addr_q};
                        wdata_d = {dhi_q, dlo_q};
                    end else begin
                        err_evt = 1'b1;
                    end
                end
                default: p_d = P_HDR;
            endcase
        end
        frame_err_d = err_evt;
        err_cnt_d   = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q         <= P_HDR;
            addr_q      <= 8'h00;
            dhi_q       <= 8'h00;
            dlo_q       <= 8'h00;
            to_cnt_q    <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= 16'h0000;
            wdata_q     <= 16'h0000;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            p_q         <= p_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            to_cnt_q    <= to_cnt_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign wr        = wr_q;
    assign frame_ok  = wr_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign frame_err = frame_err_q;
    assign err_count = err_cnt_q;
    assign rx_busy   = (rx_state_q != R_IDLE);
endmodule

// File: tb/tb_uart_dds_ctrl.sv
// tb/tb_uart_dds_ctrl.sv - scoreboard bench for uart_dds_ctrl
module tb_uart_dds_ctrl;
    localparam int         CLK_FREQ = 1_000_000;
    localparam int         BAUD     = 100_000;
    localparam int         DIV      = 10;
    localparam int         TMO      = 500;
    localparam logic [7:0] HDR      = 8'hA5;
    // Start-bit drive to wr: 2-FF sync + edge detect (3), half bit, 9 bits, 2 stages.
    localparam int         LAT      = 3 + DIV / 2 + 9 * DIV + 2;
    // byte_valid sits one cycle before LAT; the timeout fires TMO cycles later.
    localparam int         TO_LAT   = LAT - 1 + TMO;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        wr, frame_ok, frame_err, rx_busy;
    logic [15:0] waddr, wdata;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_dds_ctrl #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HEADER(HDR), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .wr(wr), .waddr(waddr), .wdata(wdata),
        .frame_ok(frame_ok), .frame_err(frame_err),
        .err_count(err_count), .rx_busy(rx_busy)
    );

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [7:0]  ecnt;
        int          at;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: frame assembly over the byte stream.
    logic [7:0]  pend[$];
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_data = 16'h0;
    int          m_ecnt = 0;
    int          last_t0;

    task automatic push_err(input int at);
        ev_t e;
        m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
        e.is_wr = 1'b0; e.addr = m_addr; e.data = m_data; e.ecnt = 8'(m_ecnt); e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int at);
        ev_t e;
        if (!stop_ok) begin
            pend.delete();
            push_err(at);
        end else if (pend.size() == 0 && b != HDR) begin
            // idle garbage
        end else begin
            pend.push_back(b);
            if (pend.size() == 5) begin
                if ((pend[1] ^ pend[2] ^ pend[3]) == pend[4]) begin
                    m_addr = {8'h00, pend[1]};
                    m_data = {pend[2], pend[3]};
                    e.is_wr = 1'b1; e.addr = m_addr; e.data = m_data;
                    e.ecnt = 8'(m_ecnt); e.at = at;
                    exp_q.push_back(e);
                end else begin
                    push_err(at);
                end
                pend.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        int t0;
        @(posedge clk); #1;
        t0 = cyc;
        last_t0 = t0;
        model_byte(b, stop_ok, t0 + LAT);
        uart_rx = 1'b0;
        repeat (DIV) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(posedge clk); #1;
        end
        uart_rx = stop_ok;
        repeat (DIV) @(posedge clk); #1;
        uart_rx = 1'b1;
        if (!stop_ok) repeat (5) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        send_byte(HDR, 1'b1);
        send_byte(a, 1'b1);
        send_byte(dh, 1'b1);
        send_byte(dl, 1'b1);
        send_byte(ck, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        pend.delete();
        m_addr = 16'h0;
        m_data = 16'h0;
        m_ecnt = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr"}, {31'b0, wr}, 32'h0);
        chk({tag, "_waddr"}, {16'b0, waddr}, 32'h0);
        chk({tag, "_wdata"}, {16'b0, wdata}, 32'h0);
        chk({tag, "_frame_ok"}, {31'b0, frame_ok}, 32'h0);
        chk({tag, "_frame_err"}, {31'b0, frame_err}, 32'h0);
        chk({tag, "_err_count"}, {24'b0, err_count}, 32'h0);
        chk({tag, "_rx_busy"}, {31'b0, rx_busy}, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        ev_t e;
        if (wr || frame_err || frame_ok) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: wr=%0b frame_err=%0b at cycle %0d expected none",
                         wr, frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ev_wr", {31'b0, wr}, {31'b0, e.is_wr});
                chk("ev_frame_ok", {31'b0, frame_ok}, {31'b0, e.is_wr});
                chk("ev_frame_err", {31'b0, frame_err}, {31'b0, !e.is_wr});
                chk("ev_cycle", cyc, e.at);
                chk("ev_waddr", {16'b0, waddr}, {16'b0, e.addr});
                chk("ev_wdata", {16'b0, wdata}, {16'b0, e.data});
                chk("ev_err_count", {24'b0, err_count}, {24'b0, e.ecnt});
            end
        end
    end

    initial begin
        logic [7:0] a, dh, dl, ck;
        int waited;
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk); #1;
        reset = 1'b0;
        chk_zero("reset");

        // 1: good frame
        send_frame(8'h20, 8'h12, 8'h34, 8'h06);
        // 2: bad checksum
        send_frame(8'h20, 8'h12, 8'h34, 8'h07);
        // 3: garbage then frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_frame(8'h20, 8'h00, 8'h01, 8'h21);

        // 4: short glitch, then framing error, then parser must be at header
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("glitch_busy_high", {31'b0, rx_busy}, 32'h1);
        uart_rx = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("glitch_busy_low", {31'b0, rx_busy}, 32'h0);
        send_byte(HDR, 1'b0);
        send_frame(8'h21, 8'hBE, 8'hEF, 8'h21 ^ 8'hBE ^ 8'hEF);

        // 5: timeout mid-frame, trailing bytes ignored
        send_byte(HDR, 1'b1);
        send_byte(8'h20, 1'b1);
        pend.delete();
        push_err(last_t0 + TO_LAT);
        repeat (600) @(posedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h06, 1'b1);

        // random frames with occasional garbage and corrupted checksums
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 8'($urandom);
                if (a == HDR) a = 8'h00;
                send_byte(a, 1'b1);
            end
            a  = 8'($urandom);
            dh = 8'($urandom);
            dl = 8'($urandom);
            ck = a ^ dh ^ dl;
            if ($urandom_range(0, 2) == 0) ck = ck ^ (8'h01 << $urandom_range(0, 7));
            send_frame(a, dh, dl, ck);
        end

        // 6: reset mid-frame discards it
        send_byte(HDR, 1'b1);
        send_byte(8'h20, 1'b1);
        do_reset();
        chk_zero("midreset");
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h06, 1'b1);

        // err_count saturation: 250 framing errors + 6 checksum errors
        for (int i = 0; i < 250; i++) send_byte(8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) send_frame(8'h20, 8'h12, 8'h34, 8'h00);

        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        chk("err_count_saturated", {24'b0, err_count}, 32'd255);
        chk("final_rx_busy", {31'b0, rx_busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_dds_ctrl.md
Name: uart_dds_ctrl

Overview:
UART command receiver and register-write initiator for the ring-modulator DDS configuration bus (wr/waddr/wdata). It decodes 8N1 serial frames from the host and issues single-cycle register writes. A typical write is the phase increment at address 0x20, which retunes the ring carrier at runtime. It sits between the board UART RX pin and the DDS write port.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, serial bit rate
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 43400, maximum clk cycles allowed between consecutive bytes inside a frame

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
uart_rx  in  1  serial input; idle high; asynchronous to clk
wr  out  1  DDS register write strobe; one cycle per accepted frame
waddr  out  16  DDS register address; valid when wr=1, held afterwards
wdata  out  16  DDS register data; valid when wr=1, held afterwards
frame_ok  out  1  one-cycle pulse, coincident with wr
frame_err  out  1  one-cycle pulse on checksum, framing or timeout error
err_count  out  8  accepted-error counter, saturates at 255
rx_busy  out  1  high while the bit receiver is inside a character

Behaviour:
- Reset (synchronous, active-high, one clk edge): wr=0, waddr=0, wdata=0, frame_ok=0, frame_err=0, err_count=0, rx_busy=0. Receiver returns to IDLE and parser to P_HDR. Any partial frame is discarded. Reset mid-frame never produces a write.
- DIV = (CLK_FREQ + BAUD/2)/BAUD (integer). uart_rx passes through a 2-FF synchroniser; all decisions use the synchronised value.
- Receiver FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a 1->0 edge enters START; rx_busy=1.
  - START: after DIV/2 cycles, sample the line. If low, enter DATA. If high, treat as a glitch and return to IDLE with no error.
  - DATA: sample every DIV cycles; 8 bits, LSB first.
  - STOP: sample after DIV cycles. If high, byte_valid pulses on the next cycle. If low, raise a framing error: frame_err pulse, err_count+1, parser forced to P_HDR, byte discarded.
  - After STOP, return to IDLE; rx_busy=0.
- Parser FSM, advancing only on byte_valid: P_HDR -> P_ADDR -> P_DHI -> P_DLO -> P_CHK -> P_HDR.
  - P_HDR: bytes other than HEADER are discarded silently with no error.
  - Inside a frame, HEADER-valued bytes are ordinary data; there is no resynchronisation.
  - Checksum = addr ^ dhi ^ dlo.
  - On a match: wr=1 and frame_ok=1 for exactly one cycle, the cycle after the checksum byte_valid. In that same cycle waddr={8'h00,addr} and wdata={dhi,dlo}.
  - On a mismatch: frame_err pulse, err_count+1, no wr. waddr and wdata are unchanged.
- Total latency: wr rises exactly 2 clk after the stop-bit sample edge of the checksum byte.
- Timeout: the counter clears on each byte_valid and runs while the parser is not in P_HDR. Reaching TIMEOUT_CYC gives a frame_err pulse, err_count+1, and parser to P_HDR. The counter does not run in P_HDR.
- err_count saturates at 255; further errors still pulse frame_err.
- Simultaneous events: a framing error in the same cycle as a timeout counts once.
- Writes are fire-and-forget; there is no back-pressure. A full frame takes 50 bit times, which bounds wr to at most one per 50·DIV cycles.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), TIMEOUT_CYC=500.
1. Send A5 20 12 34 06 -> one wr pulse with waddr=0x0020, wdata=0x1234, frame_ok coincident, wr 2 clk after the final stop sample; err_count=0.
2. Send A5 20 12 34 07 -> no wr; one frame_err pulse; err_count=1; waddr and wdata keep their previous values.
3. Send 00 FF 3C, then A5 20 00 01 21 -> garbage ignored with no error; exactly one wr with wdata=0x0001.
4. Send a 3-cycle low glitch on idle uart_rx -> no byte, no error, rx_busy returns to 0. Send byte A5 with stop bit low -> frame_err, err_count+1, parser in P_HDR.
5. Send A5 20, then idle for 600 cycles -> frame_err at 500 cycles after the second byte_valid. A following 12 34 06 produces no wr.
6. Send A5 20, assert reset for 1 cycle, then send 12 34 06 -> no wr; all outputs zero after reset. Then send 256 bad-checksum frames -> err_count stays at 255.
